// File: rtl/fc_pingpong_ctrl.sv
// fc_pingpong_ctrl: sequencing controller for the fully-connected layer engine.
// Loads an N-element vector into vector memory over valid/ready, then walks
// the M x N weight ROM row by row, strobing the accumulator and presenting
// each row result under an output valid/ready handshake.
// Optional feature macro: FC_PINGPONG_EN (two vector banks, load overlaps compute).
//
// Handshakes: a transfer happens in a cycle where both valid and ready are
// high; ready never depends combinationally on valid, and a raised
// output_valid is held until output_ready is seen.
module fc_pingpong_ctrl #(
  parameter int M         = 10,
  parameter int N         = 8,
  parameter int LOGSIZE_M = $clog2(M*N),
  parameter int LOGSIZE_X = $clog2(N)+1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 input_valid,
  output logic                 input_ready,
  output logic [LOGSIZE_X-1:0] wr_addr_x,
  output logic                 wr_en_x,
  output logic [LOGSIZE_X-1:0] rd_addr_x,
  output logic [LOGSIZE_M-1:0] addr_w,
  output logic                 clear_acc,
  output logic                 en_acc,
  output logic                 output_valid,
  input  logic                 output_ready,
  output logic                 busy
);

  localparam int KW = LOGSIZE_X-1;
  localparam int RW = (M > 1) ? $clog2(M) : 1;

`ifdef FC_PINGPONG_EN
  localparam logic PP = 1'b1;
`else
  localparam logic PP = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_FLUSH, S_HOLD} state_t;

  state_t        state_q, state_d;
  logic [RW-1:0] r_q, r_d;
  logic [KW-1:0] k_q, k_d;
  logic [KW-1:0] wcnt_q, wcnt_d;
  logic          wb_q, wb_d;
  logic          cb_q, cb_d;
  logic [1:0]    full_q, full_d;
  logic          en_acc_q, en_acc_d;
  logic          output_valid_q, output_valid_d;

  logic accept;
  logic load_done;
  logic release_bank;
  logic next_cb;
  logic chain;

`ifdef FC_PINGPONG_EN
  assign input_ready = !full_q[wb_q];
`else
  assign input_ready = (state_q == S_IDLE) && !full_q[0];
`endif

  assign accept       = input_valid && input_ready;
  assign load_done    = accept && (wcnt_q == KW'(N-1));
  assign release_bank = (state_q == S_HOLD) && output_ready && (r_q == RW'(M-1));
  // With two banks, the other bank may already hold a complete vector when the
  // last row of this one is handed off; start it right away instead of idling.
  assign next_cb      = cb_q ^ PP;
  assign chain        = PP && (full_q[next_cb] || (load_done && (wb_q == next_cb)));

  assign wr_en_x      = accept;
  assign wr_addr_x    = {(PP ? wb_q : 1'b0), wcnt_q};
  assign rd_addr_x    = {(PP ? cb_q : 1'b0), k_q};
  assign addr_w       = LOGSIZE_M'(r_q) * LOGSIZE_M'(N) + LOGSIZE_M'(k_q);
  assign en_acc       = en_acc_q;
  assign output_valid = output_valid_q;
  assign busy         = (state_q != S_IDLE);

  // Load side: element counter, write bank and bank-full flags.
  always_comb begin
    wcnt_d = wcnt_q;
    wb_d   = wb_q;
    full_d = full_q;
    if (accept) begin
      if (load_done) begin
        wcnt_d = '0;
        wb_d   = wb_q ^ PP;
      end else begin
        wcnt_d = wcnt_q + KW'(1);
      end
    end
    if (release_bank) full_d[cb_q] = 1'b0;
    if (load_done)    full_d[wb_q] = 1'b1;
  end

  // Compute FSM: next state, row/column counters and accumulator strobes.
  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    k_d       = k_q;
    cb_d      = cb_q;
    clear_acc = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Bypass the flag register so compute starts the cycle after the last accept.
        if (full_q[cb_q] || (load_done && (wb_q == cb_q))) begin
          state_d = S_ISSUE;
          r_d     = '0;
          k_d     = '0;
        end
      end
      S_ISSUE: begin
        clear_acc = (k_q == '0);
        if (k_q == KW'(N-1)) begin
          k_d     = '0;
          state_d = S_FLUSH;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      S_FLUSH: state_d = S_HOLD;
      S_HOLD: begin
        if (output_ready) begin
          if (r_q == RW'(M-1)) begin
            r_d     = '0;
            cb_d    = next_cb;
            state_d = chain ? S_ISSUE : S_IDLE;
          end else begin
            r_d     = r_q + RW'(1);
            state_d = S_ISSUE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    en_acc_d       = (state_q == S_ISSUE);
    output_valid_d = (state_d == S_HOLD);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      r_q            <= '0;
      k_q            <= '0;
      wcnt_q         <= '0;
      wb_q           <= 1'b0;
      cb_q           <= 1'b0;
      full_q         <= '0;
      en_acc_q       <= 1'b0;
      output_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      r_q            <= r_d;
      k_q            <= k_d;
      wcnt_q         <= wcnt_d;
      wb_q           <= wb_d;
      cb_q           <= cb_d;
      full_q         <= full_d;
      en_acc_q       <= en_acc_d;
      output_valid_q <= output_valid_d;
    end
  end

endmodule

// File: tb/tb_fc_pingpong_ctrl.sv
// Testbench for fc_pingpong_ctrl. Build-dependent expectations follow the
// FC_PINGPONG_EN macro, matching the DUT build.
module tb_fc_pingpong_ctrl;

  localparam int M  = 10;
  localparam int N  = 8;
  localparam int LM = $clog2(M*N);
  localparam int LX = $clog2(N)+1;
  localparam int KW = $clog2(N);
`ifdef FC_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          input_valid;
  logic          input_ready;
  logic [LX-1:0] wr_addr_x;
  logic          wr_en_x;
  logic [LX-1:0] rd_addr_x;
  logic [LM-1:0] addr_w;
  logic          clear_acc;
  logic          en_acc;
  logic          output_valid;
  logic          output_ready;
  logic          busy;

  fc_pingpong_ctrl #(.M(M), .N(N)) dut (
    .clk(clk), .reset(reset), .input_valid(input_valid), .input_ready(input_ready),
    .wr_addr_x(wr_addr_x), .wr_en_x(wr_en_x), .rd_addr_x(rd_addr_x), .addr_w(addr_w),
    .clear_acc(clear_acc), .en_acc(en_acc), .output_valid(output_valid),
    .output_ready(output_ready), .busy(busy)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;
  int en_cnt = 0;
  int vec_cnt = 0;
  logic [31:0] prev_aw, prev_rd;

  // Scoreboard queues: expected (model) and observed (monitor)
  logic [31:0] exp_wr[$], exp_aw[$], exp_rd[$], exp_clr[$], exp_hs[$], exp_acc[$];
  logic [31:0] obs_wr[$], obs_aw[$], obs_rd[$], obs_clr[$], obs_hs[$], obs_acc[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Monitor: sampled on the falling edge
  always @(negedge clk) begin
    if (!reset) begin
      chk("wr_en_vs_accept", 32'(wr_en_x), 32'(input_valid && input_ready));
      if (wr_en_x) obs_wr.push_back(32'(wr_addr_x));
      if (input_valid && input_ready) obs_acc.push_back(cyc);
      if (en_acc) begin
        obs_aw.push_back(prev_aw);
        obs_rd.push_back(prev_rd);
        en_cnt++;
      end
      if (clear_acc) obs_clr.push_back(cyc);
      if (output_valid && output_ready) obs_hs.push_back(cyc);
      if (output_valid) begin
        chk("hold_no_en", 32'(en_acc), 0);
        chk("hold_no_clr", 32'(clear_acc), 0);
      end
    end
    prev_aw = 32'(addr_w);
    prev_rd = 32'(rd_addr_x);
  end

  // Reference model: the bank a freshly loaded vector lands in
  function automatic int take_bank();
    int b;
    b = PP ? (vec_cnt % 2) : 0;
    vec_cnt++;
    return b;
  endfunction

  task automatic add_writes(input int bank);
    for (int i = 0; i < N; i++) exp_wr.push_back(bank * (1 << KW) + i);
  endtask

  // Expected compute trace of one vector whose row 0 starts at c0
  task automatic add_vector(input int bank, input int c0, input int stall_row, input int stall);
    int c;
    c = c0;
    for (int r = 0; r < M; r++) begin
      exp_clr.push_back(c);
      for (int k = 0; k < N; k++) begin
        exp_aw.push_back(r * N + k);
        exp_rd.push_back(bank * (1 << KW) + k);
      end
      c = c + N + 1 + ((r == stall_row) ? stall : 0);
      exp_hs.push_back(c);
      c = c + 1;
    end
  endtask

  task automatic clear_sb();
    exp_wr.delete(); exp_aw.delete(); exp_rd.delete(); exp_clr.delete(); exp_hs.delete(); exp_acc.delete();
    obs_wr.delete(); obs_aw.delete(); obs_rd.delete(); obs_clr.delete(); obs_hs.delete(); obs_acc.delete();
    en_cnt = 0;
  endtask

  task automatic cmp_all(input string tag);
    chk({tag, "_wr_n"}, obs_wr.size(), exp_wr.size());
    for (int i = 0; i < exp_wr.size() && i < obs_wr.size(); i++) chk({tag, "_wr_addr"}, obs_wr[i], exp_wr[i]);
    chk({tag, "_en_cnt"}, en_cnt, exp_aw.size());
    chk({tag, "_aw_n"}, obs_aw.size(), exp_aw.size());
    for (int i = 0; i < exp_aw.size() && i < obs_aw.size(); i++) chk({tag, "_addr_w"}, obs_aw[i], exp_aw[i]);
    for (int i = 0; i < exp_rd.size() && i < obs_rd.size(); i++) chk({tag, "_rd_addr"}, obs_rd[i], exp_rd[i]);
    chk({tag, "_clr_n"}, obs_clr.size(), exp_clr.size());
    for (int i = 0; i < exp_clr.size() && i < obs_clr.size(); i++) chk({tag, "_clr_cyc"}, obs_clr[i], exp_clr[i]);
    chk({tag, "_hs_n"}, obs_hs.size(), exp_hs.size());
    for (int i = 0; i < exp_hs.size() && i < obs_hs.size(); i++) chk({tag, "_hs_cyc"}, obs_hs[i], exp_hs[i]);
    for (int i = 0; i < exp_acc.size() && i < obs_acc.size(); i++) chk({tag, "_acc_cyc"}, obs_acc[i], exp_acc[i]);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_input_ready"}, 32'(input_ready), 1);
    chk({tag, "_wr_en_x"}, 32'(wr_en_x), 0);
    chk({tag, "_clear_acc"}, 32'(clear_acc), 0);
    chk({tag, "_en_acc"}, 32'(en_acc), 0);
    chk({tag, "_output_valid"}, 32'(output_valid), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_addr_w"}, 32'(addr_w), 0);
    chk({tag, "_rd_addr_x"}, 32'(rd_addr_x), 0);
    chk({tag, "_wr_addr_x"}, 32'(wr_addr_x), 0);
  endtask

  // Driver: offer cnt elements; t_start is the first drive cycle, t_last the last accept
  task automatic send(input int cnt, input bit bubbly, output int t_start, output int t_last);
    int sent;
    int guard;
    sent = 0; guard = 0; t_start = -1; t_last = -1;
    while (sent < cnt && guard < 3000) begin
      @(posedge clk); #1;
      if (guard == 0) t_start = cyc;
      guard++;
      input_valid = bubbly ? 1'($urandom_range(0, 1)) : 1'b1;
      if (input_valid && input_ready) begin
        sent++;
        t_last = cyc;
      end
    end
    @(posedge clk); #1;
    input_valid = 1'b0;
    chk("send_count", sent, cnt);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (!busy) break;
    end
    chk({tag, "_idle_timeout"}, 32'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    int ts, tl, bank, bank_b, h_a, c0_b, phase, seen;
    reset = 1'b1; input_valid = 1'b0; output_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    reset = 1'b0;
    clear_sb();

    // Single vector, bubbly input, output_ready held high
    send(N, 1'b1, ts, tl);
    bank = take_bank();
    add_writes(bank);
    add_vector(bank, tl + 1, -1, 0);
    wait_idle("single");
    cmp_all("single");
    clear_sb();

    // Output backpressure on row 3 for 5 cycles
    send(N, 1'b1, ts, tl);
    bank = take_bank();
    add_writes(bank);
    add_vector(bank, tl + 1, 3, 5);
    phase = 0; seen = 0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      if (phase == 0 && obs_clr.size() >= 4) begin
        output_ready = 1'b0;
        phase = 1;
      end else if (phase == 1 && output_valid) begin
        if (seen == 5) begin
          output_ready = 1'b1;
          phase = 2;
        end else begin
          chk("bp_en_acc", 32'(en_acc), 0);
          chk("bp_clear_acc", 32'(clear_acc), 0);
          chk("bp_addr_w_le31", 32'(addr_w <= LM'(31)), 1);
          seen++;
        end
      end else if (phase == 2 && !busy) begin
        break;
      end
    end
    output_ready = 1'b1;
    chk("bp_stall_cycles", seen, 5);
    chk("bp_idle_timeout", 32'(busy), 0);
    cmp_all("backpressure");
    clear_sb();

    // Two vectors offered back to back
    send(2 * N, 1'b0, ts, tl);
    chk("ovl_ready_low", 32'(input_ready), 0);
    bank   = take_bank();
    bank_b = take_bank();
    add_writes(bank);
    add_writes(bank_b);
    h_a = ts + N + (M - 1) * (N + 2) + N + 1;
    for (int i = 0; i < N; i++) exp_acc.push_back(ts + i);
    for (int i = 0; i < N; i++) exp_acc.push_back(PP ? (ts + N + i) : (h_a + 1 + i));
    c0_b = PP ? (h_a + 1) : (h_a + N + 1);
    add_vector(bank, ts + N, -1, 0);
    add_vector(bank_b, c0_b, -1, 0);
    wait_idle("overlap");
    chk("ovl_acc_n", obs_acc.size(), 2 * N);
    cmp_all("overlap");
    clear_sb();

    // Reset during row 4, k=5
    send(N, 1'b0, ts, tl);
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      if (obs_clr.size() >= 5) break;
    end
    chk("mid_row4_reached", obs_clr.size(), 5);
    repeat (4) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    check_reset_vals("midreset");
    reset = 1'b0;
    vec_cnt = 0;
    clear_sb();

    // Fresh vector after reset
    send(N, 1'b1, ts, tl);
    bank = take_bank();
    add_writes(bank);
    add_vector(bank, tl + 1, -1, 0);
    wait_idle("postreset");
    cmp_all("postreset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
